fetch_prefetch_q: RTL and testbench
===================================

Name: fetch_prefetch_q

Overview:
- Parametrised successor to the single-entry IF stage: a decoupled instruction fetch unit with an in-order DEPTH-entry prefetch queue.
- Issues sequential imem requests ahead of decode using a request/grant handshake with credit-based flow control.
- On a redirect (jump/branch/trap/mret target, computed upstream), flushes the queue and discards all in-flight responses.
- Sits between imem_ctrl and dec, replacing the fetch buffer regs used when ITCM is absent.

Parameters:
ADDR_WIDTH, 32, fetch address width
INSTR_WIDTH, 32, instruction word width
DEPTH, 4, queue entries; power of 2, >=2; also the max outstanding-plus-buffered count

Ports:
cpu_clk  input  1  cpu clock
cpu_rst  input  1  asynchronous reset, active-high
boot_addr  input  ADDR_WIDTH  first fetch address after reset
redirect  input  1  single-cycle request to restart fetch at redirect_pc
redirect_pc  input  ADDR_WIDTH  new fetch target
halt  input  1  stop issuing new requests (dbg_mode); responses still accepted
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_WIDTH  fetch address (= fetch_pc)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  in-order response valid, >=1 cycle after its grant
imem_rdata  input  INSTR_WIDTH  response instruction
if_valid  output  1  queue head valid to dec
instr_dec  output  INSTR_WIDTH  head instruction
pc_dec  output  ADDR_WIDTH  head instruction PC
dec_ready  input  1  dec consumes head when if_valid && dec_ready
pc_misaligned  output  1  fetch_pc[1:0] != 0
fault_pc  output  ADDR_WIDTH  fetch_pc when misaligned, else 0

Behaviour:
- Reset: fetch_pc=boot_addr, resp_pc=boot_addr, queue empty, inflight=0, discard=0; imem_req=0 during reset; if_valid=0, instr_dec=0, pc_dec=0 while empty.
- Credit: imem_req = !cpu_rst && !redirect && !halt && !pc_misaligned && (count + inflight) < DEPTH.
- Grant (imem_req && imem_gnt): fetch_pc <= fetch_pc+4, modulo 2^ADDR_WIDTH; inflight+1.
- Response (imem_rvalid): inflight-1.
  - If discard>0: discard-1; response dropped.
  - Else: push {resp_pc, imem_rdata}; resp_pc <= resp_pc+4.
  - Grant and response in the same cycle leave inflight unchanged.
- Queue is first-word-fall-through: if_valid = !empty && !redirect; head drives instr_dec/pc_dec; pop on if_valid && dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pushing into a full queue is impossible under the credit rule; assert it.
- Latency: grant at cycle t, rvalid at t+k, then if_valid=1 at t+k+1.
- Redirect cycle:
  - imem_req=0; no pop.
  - Next cycle: queue empty; fetch_pc=resp_pc=redirect_pc; discard = inflight_next, where inflight_next = inflight - rvalid_this_cycle. The rvalid in the redirect cycle is also dropped.
  - First new request is issued the cycle after the redirect.
- Back-to-back redirects: the later one wins; discard is recomputed each time, so no stale response ever reaches dec.
- Misaligned target: fetch_pc keeps the value; pc_misaligned=1 and fault_pc=fetch_pc until the next redirect; no requests issued. Queue drains normally.
- halt: blocks new requests only; in-flight responses are pushed and the queue drains to dec.
- Counters: inflight and discard are clog2(DEPTH+1) bits; count+inflight <= DEPTH always; discard <= inflight always.
- Reset mid-operation (async): all state returns to reset values immediately; late imem responses are imem_ctrl's responsibility to squash.

Test Plan:
- Streaming: boot_addr=0x100, gnt=1 always, rvalid 1 cycle after gnt, dec_ready=1 -> imem_addr 0x100,0x104,0x108...; pc_dec sequence matches; continuous if_valid after fill.
- Backpressure: DEPTH=4, dec_ready=0 -> exactly 4 grants, then imem_req=0; count=4. dec_ready=1 for one cycle -> one pop, one new request next cycle.
- Redirect with 2 in flight: redirect_pc=0x2000 while inflight=2 -> the next 2 rvalids are dropped; queue empty; next imem_addr=0x2000; first pc_dec=0x2000.
- Redirect coincident with rvalid and with a dec_ready pop attempt -> that response is dropped; no pop; if_valid=0 that cycle; discard=inflight-1.
- Misaligned redirect to 0x2002 -> pc_misaligned=1, fault_pc=0x2002, imem_req=0. A later redirect to 0x3000 clears it and fetch resumes.
- Wrap and halt: boot_addr=0xFFFFFFFC -> second request at 0x00000000. Asserting halt mid-stream stops requests while outstanding responses still reach dec.

Source files
------------

// File: rtl/fetch_prefetch_q.sv
// Decoupled instruction fetch unit. It issues sequential imem requests ahead
// of decode and buffers the responses in an in-order first-word-fall-through
// prefetch queue. Credits bound the total of buffered plus outstanding fetches
// to DEPTH, so a response always has a free slot. A redirect flushes the queue
// and marks every still-outstanding response for discard.
module fetch_prefetch_q #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [ADDR_WIDTH-1:0]  boot_addr,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] instr_dec,
  output logic [ADDR_WIDTH-1:0]  pc_dec,
  input  logic                   dec_ready,
  output logic                   pc_misaligned,
  output logic [ADDR_WIDTH-1:0]  fault_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 1;

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  resp_pc;
  logic [CW-1:0]          count;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          inflight_next;
  logic [CW-1:0]          discard;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [INSTR_WIDTH-1:0] q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0]  q_pc    [DEPTH];

  logic empty;
  logic full;
  logic credit_ok;
  logic grant;
  logic drop;
  logic push;
  logic pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign credit_ok = (SW'(count) + SW'(inflight)) < SW'(DEPTH);

  assign pc_misaligned = (fetch_pc[1:0] != 2'b00);
  assign fault_pc      = pc_misaligned ? fetch_pc : '0;

  assign imem_req  = !cpu_rst && !redirect && !halt && !pc_misaligned && credit_ok;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign drop = imem_rvalid && (redirect || (discard != '0));
  assign push = imem_rvalid && !drop;

  assign if_valid  = !empty && !redirect;
  assign pop       = if_valid && dec_ready;
  assign instr_dec = empty ? '0 : q_instr[rd_ptr];
  assign pc_dec    = empty ? '0 : q_pc[rd_ptr];

  // Outstanding-request count after this cycle's grant and response.
  always_comb begin
    inflight_next = inflight;
    case ({grant, imem_rvalid})
      2'b10:   inflight_next = inflight + CW'(1);
      2'b01:   inflight_next = inflight - CW'(1);
      default: inflight_next = inflight;
    endcase
  end

  // Fetch/response PCs, queue pointers and credit counters.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      fetch_pc <= boot_addr;
      resp_pc  <= boot_addr;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        discard  <= inflight_next;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
        if (push) begin
          resp_pc <= resp_pc + ADDR_WIDTH'(4);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (!push && pop) begin
          count <= count - CW'(1);
        end
        if (imem_rvalid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  // Queue storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_no_push_full: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    push |-> !full);
  a_rvalid_has_req: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    imem_rvalid |-> (inflight != '0));
  a_credit_bound: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    (SW'(count) + SW'(inflight)) <= SW'(DEPTH));
  a_discard_bound: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    discard <= inflight);

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Directed bench for fetch_prefetch_q. A small imem responder inside the
// cycle task answers each grant one cycle later with rdata = addr ^ K.
module tb_fetch_prefetch_q;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] boot_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] instr_dec;
  logic [31:0] pc_dec;
  logic        dec_ready;
  logic        pc_misaligned;
  logic [31:0] fault_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_grants = 0;
  bit          auto_resp;
  logic [31:0] pend[$];

  fetch_prefetch_q dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .boot_addr     (boot_addr),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .instr_dec     (instr_dec),
    .pc_dec        (pc_dec),
    .dec_ready     (dec_ready),
    .pc_misaligned (pc_misaligned),
    .fault_pc      (fault_pc)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Advance one clock: log this cycle's grant, then present the next response.
  task automatic cycle();
    if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
      pend.push_back(imem_addr);
      n_grants++;
    end
    @(negedge cpu_clk);
    redirect = 1'b0;
    if (auto_resp && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend.pop_front() ^ K;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] boot);
    cpu_rst     = 1'b1;
    boot_addr   = boot;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    dec_ready   = 1'b0;
    imem_gnt    = 1'b1;
    auto_resp   = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend.delete();
    cycle();
    cycle();
    cpu_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    cpu_rst     = 1'b1;
    boot_addr   = 32'h100;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    dec_ready   = 1'b1;
    imem_gnt    = 1'b1;
    auto_resp   = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cycle();
    cycle();
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_checks++;
    if (pc_dec !== 32'h0 || instr_dec !== 32'h0) begin
      n_fail++; $display("FAIL reset_head: pc %h instr %h want 0 0", pc_dec, instr_dec);
    end
    n_checks++;
    if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL reset_addr: got %h want 00000100", imem_addr); end
    n_checks++;
    if (pc_misaligned !== 1'b0 || fault_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_fault: mis %b fault %h want 0 0", pc_misaligned, fault_pc);
    end
    cpu_rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %b want 1", imem_req); end
  endtask

  task automatic test_streaming();
    logic [31:0] ea;
    logic [31:0] ep;
    do_reset(32'h100);
    dec_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      ea = 32'h100 + 32'(4 * i);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== ea) begin
        n_fail++; $display("FAIL stream_req[%0d]: req %b addr %h want 1 %h", i, imem_req, imem_addr, ea);
      end
      n_checks++;
      if (i >= 2) begin
        ep = 32'h100 + 32'(4 * (i - 2));
        if (if_valid !== 1'b1 || pc_dec !== ep || instr_dec !== (ep ^ K)) begin
          n_fail++;
          $display("FAIL stream_head[%0d]: valid %b pc %h instr %h want 1 %h %h",
                   i, if_valid, pc_dec, instr_dec, ep, ep ^ K);
        end
      end else begin
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_fill[%0d]: valid %b want 0", i, if_valid); end
      end
      cycle();
    end
  endtask

  task automatic test_async_reset();
    do_reset(32'h100);
    dec_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) cycle();
    boot_addr = 32'h400;
    cpu_rst   = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc_dec !== 32'h0) begin
      n_fail++; $display("FAIL async_rst_outputs: req %b valid %b pc %h want 0 0 0", imem_req, if_valid, pc_dec);
    end
    n_checks++;
    if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL async_rst_addr: got %h want 00000400", imem_addr); end
    do_reset(32'h400);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
      n_fail++; $display("FAIL async_rst_resume: req %b addr %h want 1 00000400", imem_req, imem_addr);
    end
  endtask

  task automatic test_backpressure();
    do_reset(32'h100);
    dec_ready = 1'b0;
    #1;
    n_grants = 0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (imem_req !== (i < 4)) begin
        n_fail++; $display("FAIL bp_req[%0d]: got %b want %b", i, imem_req, (i < 4));
      end
      cycle();
    end
    n_checks++;
    if (n_grants != 4) begin n_fail++; $display("FAIL bp_grants: got %0d want 4", n_grants); end
    n_checks++;
    if (if_valid !== 1'b1 || pc_dec !== 32'h100) begin
      n_fail++; $display("FAIL bp_head: valid %b pc %h want 1 00000100", if_valid, pc_dec);
    end
    dec_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_pop_req: got %b want 0", imem_req); end
    cycle();
    dec_ready = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h110 || pc_dec !== 32'h104) begin
      n_fail++; $display("FAIL bp_refill: req %b addr %h pc %h want 1 00000110 00000104", imem_req, imem_addr, pc_dec);
    end
    cycle();
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_again: got %b want 0", imem_req); end
  endtask

  task automatic test_redirect_inflight();
    do_reset(32'h100);
    dec_ready = 1'b1;
    auto_resp = 1'b0;
    #1;
    cycle();
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h2000;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle: req %b valid %b want 0 0", imem_req, if_valid);
    end
    cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      n_fail++; $display("FAIL redir_new_req: req %b addr %h want 1 00002000", imem_req, imem_addr);
    end
    auto_resp = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if_valid !== 1'b0) begin
        n_fail++; $display("FAIL redir_discard[%0d]: valid %b pc %h want 0", i, if_valid, pc_dec);
      end
      cycle();
    end
    n_checks++;
    if (if_valid !== 1'b1 || pc_dec !== 32'h2000 || instr_dec !== (32'h2000 ^ K)) begin
      n_fail++; $display("FAIL redir_first: valid %b pc %h instr %h want 1 00002000 %h",
                         if_valid, pc_dec, instr_dec, 32'h2000 ^ K);
    end
    cycle();
    n_checks++;
    if (if_valid !== 1'b1 || pc_dec !== 32'h2004) begin
      n_fail++; $display("FAIL redir_second: valid %b pc %h want 1 00002004", if_valid, pc_dec);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(32'h100);
    dec_ready = 1'b1;
    #1;
    cycle();
    cycle();
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rv_redir_cycle: valid %b req %b want 0 0", if_valid, imem_req);
    end
    cycle();
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      n_fail++; $display("FAIL rv_after: valid %b req %b addr %h want 0 1 00003000", if_valid, imem_req, imem_addr);
    end
    cycle();
    n_checks++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rv_dropped: valid %b pc %h want 0", if_valid, pc_dec); end
    cycle();
    n_checks++;
    if (if_valid !== 1'b1 || pc_dec !== 32'h3000) begin
      n_fail++; $display("FAIL rv_first: valid %b pc %h want 1 00003000", if_valid, pc_dec);
    end
  endtask

  task automatic test_misaligned();
    do_reset(32'h100);
    dec_ready = 1'b1;
    #1;
    n_checks++;
    if (pc_misaligned !== 1'b0 || fault_pc !== 32'h0) begin
      n_fail++; $display("FAIL mis_aligned_start: mis %b fault %h want 0 0", pc_misaligned, fault_pc);
    end
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h2002;
    #1;
    cycle();
    n_checks++;
    if (pc_misaligned !== 1'b1 || fault_pc !== 32'h2002 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mis_flag: mis %b fault %h req %b want 1 00002002 0", pc_misaligned, fault_pc, imem_req);
    end
    cycle();
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h2002) begin
      n_fail++; $display("FAIL mis_hold: req %b valid %b addr %h want 0 0 00002002", imem_req, if_valid, imem_addr);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    #1;
    cycle();
    n_checks++;
    if (pc_misaligned !== 1'b0 || fault_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      n_fail++; $display("FAIL mis_clear: mis %b fault %h req %b addr %h want 0 0 1 00003000",
                         pc_misaligned, fault_pc, imem_req, imem_addr);
    end
    cycle();
    cycle();
    n_checks++;
    if (if_valid !== 1'b1 || pc_dec !== 32'h3000) begin
      n_fail++; $display("FAIL mis_resume: valid %b pc %h want 1 00003000", if_valid, pc_dec);
    end
  endtask

  task automatic test_wrap_halt();
    do_reset(32'hFFFF_FFFC);
    dec_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: addr %h want fffffffc", imem_addr); end
    cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_second: req %b addr %h want 1 00000000", imem_req, imem_addr);
    end
    cycle();
    halt = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || pc_dec !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL halt_head0: req %b valid %b pc %h want 0 1 fffffffc", imem_req, if_valid, pc_dec);
    end
    cycle();
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || pc_dec !== 32'h0 || instr_dec !== K) begin
      n_fail++; $display("FAIL halt_head1: req %b valid %b pc %h instr %h want 0 1 00000000 %h",
                         imem_req, if_valid, pc_dec, instr_dec, K);
    end
    cycle();
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL halt_drained: req %b valid %b addr %h want 0 0 00000004", imem_req, if_valid, imem_addr);
    end
    halt = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL halt_release: req %b want 1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_async_reset();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_misaligned();
    test_wrap_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
